neuron_backprop: RTL and testbench

- Backward-pass counterpart of the forward 2-input sigmoid neuron in the trainable XOR network.
- Takes the forward operands and activation plus the upstream error dL/dout.
- Computes the local delta and the weight and bias gradients, the updated weight0, weight1 and bias, and the errors propagated back to each input.
- Uses one shared fixed-point multiplier, sequenced by an FSM; one product per cycle.

---
 rtl/nn_fixed_pkg.sv | 53 +++++
 rtl/fx_mul_sat.sv | 15 +
 rtl/neuron_backprop.sv | 124 ++++++++++++
 tb/tb_neuron_backprop.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_fixed_pkg.sv
// Q8.8 fixed-point helpers and the backprop sequencer state type shared by the XOR-network neuron blocks.
package nn_fixed_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned PROD_W    = 32;
  localparam int unsigned FRAC_BITS = 8;

  typedef logic signed [DATA_W-1:0] q_t;

  localparam q_t ONE   = 16'sd256;
  localparam q_t Q_MAX = 16'sh7fff;
  localparam q_t Q_MIN = 16'sh8000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DERIV,
    S_DELTA,
    S_GRAD0,
    S_GRAD1,
    S_ERRB0,
    S_ERRB1,
    S_UPD0,
    S_UPD1,
    S_UPDB,
    S_DONE
  } bp_state_t;

  // Round-to-nearest (add half LSB) then arithmetic shift and saturate to Q8.8.
  function automatic q_t round_shift_sat(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W:0] r;
    logic signed [PROD_W:0] s;
    r = (PROD_W+1)'(p) + (PROD_W+1)'(128);
    s = r >>> FRAC_BITS;
    if (s > (PROD_W+1)'(Q_MAX)) return Q_MAX;
    if (s < (PROD_W+1)'(Q_MIN)) return Q_MIN;
    return DATA_W'(s);
  endfunction

  function automatic q_t sub_sat(input q_t a, input q_t b);
    logic signed [DATA_W:0] d;
    d = (DATA_W+1)'(a) - (DATA_W+1)'(b);
    if (d > (DATA_W+1)'(Q_MAX)) return Q_MAX;
    if (d < (DATA_W+1)'(Q_MIN)) return Q_MIN;
    return DATA_W'(d);
  endfunction

  function automatic q_t clamp_unit(input q_t x);
    if (x < 16'sd0) return 16'sd0;
    if (x > ONE) return ONE;
    return x;
  endfunction

endpackage

// File: rtl/fx_mul_sat.sv
// Combinational signed Q8.8 multiplier with round-to-nearest and saturation.
module fx_mul_sat
  import nn_fixed_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] p_c
);

  logic signed [PROD_W-1:0] prod;

  assign prod = PROD_W'(a) * PROD_W'(b);
  assign p_c  = round_shift_sat(prod);

endmodule

// File: rtl/neuron_backprop.sv
// Backward pass of the 2-input sigmoid neuron: one shared multiplier, one product per state.
// Optional gradient clamping before the learning-rate multiply: define GRAD_CLIP_EN.
module neuron_backprop
  import nn_fixed_pkg::*;
#(
  parameter int unsigned dataWidth = 16,
  parameter int unsigned fracBits  = 8,
  parameter logic signed [15:0] gradClip = 16'sd1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [dataWidth-1:0] input0,
  input  logic [dataWidth-1:0] input1,
  input  logic [dataWidth-1:0] weight0,
  input  logic [dataWidth-1:0] weight1,
  input  logic [dataWidth-1:0] bias,
  input  logic [dataWidth-1:0] act_out,
  input  logic [dataWidth-1:0] err_in,
  input  logic [dataWidth-1:0] lr,
  output logic [dataWidth-1:0] new_weight0,
  output logic [dataWidth-1:0] new_weight1,
  output logic [dataWidth-1:0] new_bias,
  output logic [dataWidth-1:0] err_back0,
  output logic [dataWidth-1:0] err_back1,
  output logic                 busy,
  output logic                 out_valid
);

  localparam q_t ONE_L = 16'(1 << fracBits);
`ifdef GRAD_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  bp_state_t state, state_d;

  q_t in0_q, in1_q, w0_q, w1_q, b_q, act_q, err_q, lr_q;
  q_t d_q, delta_q, g0_q, g1_q;
  q_t mul_a, mul_b, prod_c;

  function automatic q_t clip_g(input q_t g);
    if (!CLIP_ON) return g;
    if (g > gradClip) return gradClip;
    if (g < -gradClip) return -gradClip;
    return g;
  endfunction

  fx_mul_sat u_mul (
    .a   (mul_a),
    .b   (mul_b),
    .p_c (prod_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next state and multiplier operand select.
  always_comb begin
    state_d = state;
    mul_a   = '0;
    mul_b   = '0;
    case (state)
      S_IDLE:  if (start) state_d = S_DERIV;
      S_DERIV: begin state_d = S_DELTA; mul_a = act_q;   mul_b = ONE_L - act_q; end
      S_DELTA: begin state_d = S_GRAD0; mul_a = err_q;   mul_b = d_q;           end
      S_GRAD0: begin state_d = S_GRAD1; mul_a = delta_q; mul_b = in0_q;         end
      S_GRAD1: begin state_d = S_ERRB0; mul_a = delta_q; mul_b = in1_q;         end
      S_ERRB0: begin state_d = S_ERRB1; mul_a = delta_q; mul_b = w0_q;          end
      S_ERRB1: begin state_d = S_UPD0;  mul_a = delta_q; mul_b = w1_q;          end
      S_UPD0:  begin state_d = S_UPD1;  mul_a = lr_q;    mul_b = clip_g(g0_q);  end
      S_UPD1:  begin state_d = S_UPDB;  mul_a = lr_q;    mul_b = clip_g(g1_q);  end
      S_UPDB:  begin state_d = S_DONE;  mul_a = lr_q;    mul_b = clip_g(delta_q); end
      S_DONE:  if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, intermediate products and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in0_q <= '0; in1_q <= '0; w0_q <= '0; w1_q <= '0;
      b_q <= '0; act_q <= '0; err_q <= '0; lr_q <= '0;
      d_q <= '0; delta_q <= '0; g0_q <= '0; g1_q <= '0;
      new_weight0 <= '0; new_weight1 <= '0; new_bias <= '0;
      err_back0 <= '0; err_back1 <= '0;
      busy <= 1'b0; out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          in0_q     <= input0;
          in1_q     <= input1;
          w0_q      <= weight0;
          w1_q      <= weight1;
          b_q       <= bias;
          act_q     <= clamp_unit($signed(act_out));
          err_q     <= err_in;
          lr_q      <= lr;
          busy      <= 1'b1;
          out_valid <= 1'b0;
        end
        S_DERIV: d_q       <= prod_c;
        S_DELTA: delta_q   <= prod_c;
        S_GRAD0: g0_q      <= prod_c;
        S_GRAD1: g1_q      <= prod_c;
        S_ERRB0: err_back0 <= prod_c;
        S_ERRB1: err_back1 <= prod_c;
        S_UPD0:  new_weight0 <= sub_sat(w0_q, prod_c);
        S_UPD1:  new_weight1 <= sub_sat(w1_q, prod_c);
        S_UPDB: begin
          new_bias  <= sub_sat(b_q, prod_c);
          out_valid <= 1'b1;
          busy      <= 1'b0;
        end
        S_DONE: if (!start) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_backprop.sv
// Randomized and directed checks of neuron_backprop against an integer reference model.
module tb_neuron_backprop;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] input0 = '0, input1 = '0, weight0 = '0, weight1 = '0, bias = '0;
  logic [15:0] act_out = '0, err_in = '0, lr = '0;
  logic [15:0] new_weight0, new_weight1, new_bias, err_back0, err_back1;
  logic        busy, out_valid;

  int total = 0;
  int bad   = 0;

  int s_in0, s_in1, s_w0, s_w1, s_b, s_act, s_err, s_lr;
  int e_w0, e_w1, e_b, e_eb0, e_eb1;

  neuron_backprop dut (
    .clk(clk), .rst(rst), .start(start),
    .input0(input0), .input1(input1), .weight0(weight0), .weight1(weight1),
    .bias(bias), .act_out(act_out), .err_in(err_in), .lr(lr),
    .new_weight0(new_weight0), .new_weight1(new_weight1), .new_bias(new_bias),
    .err_back0(err_back0), .err_back1(err_back1),
    .busy(busy), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Round half up: floor((a*b + 128) / 256), then saturate.
  function automatic int fxm(input int a, input int b);
    longint n, q;
    n = longint'(a) * longint'(b) + 128;
    q = n / 256;
    if (n < 0 && (n % 256) != 0) q = q - 1;
    return sat16(q);
  endfunction

  function automatic int clipg(input int g);
`ifdef GRAD_CLIP_EN
    if (g > 1024) return 1024;
    if (g < -1024) return -1024;
`endif
    return g;
  endfunction

  task automatic model();
    int a, d, dl, g0, g1;
    a  = (s_act < 0) ? 0 : (s_act > 256) ? 256 : s_act;
    d  = fxm(a, 256 - a);
    dl = fxm(s_err, d);
    g0 = fxm(dl, s_in0);
    g1 = fxm(dl, s_in1);
    e_eb0 = fxm(dl, s_w0);
    e_eb1 = fxm(dl, s_w1);
    e_w0  = sat16(longint'(s_w0) - fxm(s_lr, clipg(g0)));
    e_w1  = sat16(longint'(s_w1) - fxm(s_lr, clipg(g1)));
    e_b   = sat16(longint'(s_b)  - fxm(s_lr, clipg(dl)));
  endtask

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic drive();
    input0 = 16'(s_in0); input1 = 16'(s_in1);
    weight0 = 16'(s_w0); weight1 = 16'(s_w1); bias = 16'(s_b);
    act_out = 16'(s_act); err_in = 16'(s_err); lr = 16'(s_lr);
  endtask

  task automatic scramble();
    input0 = 16'($urandom); input1 = 16'($urandom); weight0 = 16'($urandom);
    weight1 = 16'($urandom); bias = 16'($urandom); act_out = 16'($urandom);
    err_in = 16'($urandom); lr = 16'($urandom);
  endtask

  // One operation; pulse=1 drops start after capture and re-pulses it while busy.
  task automatic run_op(input string tag, input bit pulse);
    int n;
    bit seen;
    model();
    @(negedge clk);
    drive();
    start = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        check_val({tag, "_busy"}, int'(busy), 1);
        check_val({tag, "_vlow"}, int'(out_valid), 0);
        scramble();
        if (pulse) start = 1'b0;
      end
      if (pulse && n == 3) start = 1'b1;
      if (pulse && n == 4) start = 1'b0;
      if (out_valid) seen = 1'b1;
    end
    check_val({tag, "_lat"}, n, 10);
    check_val({tag, "_done_busy"}, int'(busy), 0);
    check_val({tag, "_w0"}, sx(new_weight0), e_w0);
    check_val({tag, "_w1"}, sx(new_weight1), e_w1);
    check_val({tag, "_b"}, sx(new_bias), e_b);
    check_val({tag, "_eb0"}, sx(err_back0), e_eb0);
    check_val({tag, "_eb1"}, sx(err_back1), e_eb1);
  endtask

  task automatic release_start(input string tag);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check_val({tag, "_vclr"}, int'(out_valid), 0);
  endtask

  task automatic set_op(input int i0, input int i1, input int w0, input int w1,
                        input int b, input int act, input int err, input int l);
    s_in0 = i0; s_in1 = i1; s_w0 = w0; s_w1 = w1;
    s_b = b; s_act = act; s_err = err; s_lr = l;
  endtask

  initial begin
    #12;
    check_val("rst_w0", sx(new_weight0), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_valid", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;

    // Nominal, with independent constant expectations.
    set_op(256, 0, 256, -256, 0, 128, 256, 256);
    run_op("nom", 1'b0);
    check_val("nom_k_w0", sx(new_weight0), 192);
    check_val("nom_k_w1", sx(new_weight1), -256);
    check_val("nom_k_b", sx(new_bias), -64);
    check_val("nom_k_eb0", sx(err_back0), 64);
    check_val("nom_k_eb1", sx(err_back1), -64);
    // start held: no restart.
    repeat (4) begin
      @(posedge clk); #1;
      check_val("hold_valid", int'(out_valid), 1);
      check_val("hold_busy", int'(busy), 0);
    end
    release_start("nom");

    set_op(32767, 0, 32767, 0, 0, 128, -32768, 256);
    run_op("sat", 1'b0);
`ifdef GRAD_CLIP_EN
    check_val("clip_k_b", sx(new_bias), 1024);
`else
    check_val("sat_k_eb0", sx(err_back0), -32768);
`endif
    check_val("sat_k_w0", sx(new_weight0), 32767);
    release_start("sat");

    set_op(300, -200, 500, -700, 90, 256, 256, 256);
    run_op("dedge256", 1'b0);
    release_start("dedge256");
    set_op(300, -200, 500, -700, 90, 300, 256, 256);
    run_op("dedge300", 1'b0);
    check_val("dedge300_k_w0", sx(new_weight0), 500);
    release_start("dedge300");

    // Start pulse while busy must not disturb or re-trigger.
    set_op(100, 200, -300, 400, 50, 77, -600, 128);
    run_op("pulse", 1'b1);
    @(posedge clk); #1;
    check_val("pulse_vclr", int'(out_valid), 0);
    repeat (3) begin
      @(posedge clk); #1;
      check_val("pulse_idle", int'(busy), 0);
    end

    // Reset while in GRAD1.
    set_op(256, 0, 256, -256, 0, 128, 256, 256);
    @(negedge clk);
    drive();
    start = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    #1;
    check_val("mid_w0", sx(new_weight0), 0);
    check_val("mid_eb0", sx(err_back0), 0);
    check_val("mid_busy", int'(busy), 0);
    check_val("mid_valid", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check_val("mid_idle", int'(busy), 0);
    end
    run_op("after_rst", 1'b0);
    release_start("after_rst");

    for (int k = 0; k < 25; k++) begin
      set_op(int'($signed(16'($urandom))), int'($signed(16'($urandom))),
             int'($signed(16'($urandom))), int'($signed(16'($urandom))),
             int'($signed(16'($urandom))), int'($urandom_range(0, 400)) - 40,
             int'($signed(16'($urandom))), int'($urandom_range(0, 512)));
      if (k % 3 == 0) begin
        s_in0 = s_in0 / 64; s_w0 = s_w0 / 64; s_err = s_err / 64;
      end
      run_op("rnd", 1'b0);
      release_start("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
